// File: rtl/wb_regfile_if.sv
// Write-back bundle, decode read ports and retire count between the pipeline and wb_regfile.
// Define RUN_TRACE_EN to add the debug_wb_* commit trace signals.
interface wb_regfile_if #(parameter int RETIRE_W = 32);
  logic                wb_valid;
  logic                wb_we;
  logic [4:0]          wb_waddr;
  logic [31:0]         wb_wdata;
  logic [31:0]         wb_pc;
  logic [4:0]          rs1_addr;
  logic [4:0]          rs2_addr;
  logic [31:0]         rs1_data;
  logic [31:0]         rs2_data;
  logic [RETIRE_W-1:0] retire_cnt;
`ifdef RUN_TRACE_EN
  logic                debug_wb_have_inst;
  logic [31:0]         debug_wb_pc;
  logic                debug_wb_ena;
  logic [4:0]          debug_wb_reg;
  logic [31:0]         debug_wb_value;
`endif

  modport master (
    output wb_valid, wb_we, wb_waddr, wb_wdata, wb_pc, rs1_addr, rs2_addr,
    input  rs1_data, rs2_data, retire_cnt
`ifdef RUN_TRACE_EN
    , input debug_wb_have_inst, debug_wb_pc, debug_wb_ena, debug_wb_reg, debug_wb_value
`endif
  );

  modport slave (
    input  wb_valid, wb_we, wb_waddr, wb_wdata, wb_pc, rs1_addr, rs2_addr,
    output rs1_data, rs2_data, retire_cnt
`ifdef RUN_TRACE_EN
    , output debug_wb_have_inst, debug_wb_pc, debug_wb_ena, debug_wb_reg, debug_wb_value
`endif
  );
endinterface

// File: rtl/wb_regfile.sv
// WB-stage commit into the 32x32 register file with two bypassed combinational read ports
// and a retired-instruction counter. Define RUN_TRACE_EN for the registered commit trace.
module wb_regfile #(
  parameter int RETIRE_W = 32
) (
  input  logic         cpu_clk,
  input  logic         cpu_rst_n,
  wb_regfile_if.slave  bus
);
  localparam int NUM_RD = 2;

  logic [31:0]             regs [1:31];
  logic                    commit;
  logic [RETIRE_W-1:0]     retire_cnt;
  logic [NUM_RD-1:0][4:0]  rd_addr;
  logic [NUM_RD-1:0][31:0] rd_data;

  // Gating with reset keeps the bypass quiet while reset is held.
  assign commit = cpu_rst_n & bus.wb_valid & bus.wb_we & (bus.wb_waddr != 5'd0);

  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      for (int i = 1; i < 32; i++) regs[i] <= '0;
    end else if (commit) begin
      regs[bus.wb_waddr] <= bus.wb_wdata;
    end
  end

  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n)        retire_cnt <= '0;
    else if (bus.wb_valid) retire_cnt <= retire_cnt + RETIRE_W'(1);
  end

  assign bus.retire_cnt = retire_cnt;
  assign rd_addr[0]     = bus.rs1_addr;
  assign rd_addr[1]     = bus.rs2_addr;

  always_comb begin
    rd_data = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      if (rd_addr[p] == 5'd0)                         rd_data[p] = '0;
      else if (commit && bus.wb_waddr == rd_addr[p])  rd_data[p] = bus.wb_wdata;
      else                                            rd_data[p] = regs[rd_addr[p]];
    end
  end

  assign bus.rs1_data = rd_data[0];
  assign bus.rs2_data = rd_data[1];

`ifdef RUN_TRACE_EN
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      bus.debug_wb_have_inst <= 1'b0;
      bus.debug_wb_pc        <= '0;
      bus.debug_wb_ena       <= 1'b0;
      bus.debug_wb_reg       <= '0;
      bus.debug_wb_value     <= '0;
    end else begin
      bus.debug_wb_have_inst <= bus.wb_valid;
      bus.debug_wb_pc        <= bus.wb_pc;
      bus.debug_wb_ena       <= commit;
      bus.debug_wb_reg       <= bus.wb_waddr;
      bus.debug_wb_value     <= bus.wb_wdata;
    end
  end
`else
  logic unused_pc;
  assign unused_pc = ^bus.wb_pc;
`endif
endmodule

// File: tb/tb_wb_regfile.sv
// Randomized + directed scoreboard bench for wb_regfile; a 32-bit and a 4-bit retire
// counter instance share one stimulus stream.
module tb_wb_regfile;
  logic cpu_clk = 1'b0;
  logic cpu_rst_n;
  always #5 cpu_clk = ~cpu_clk;

  wb_regfile_if #(.RETIRE_W(32)) bus ();
  wb_regfile_if #(.RETIRE_W(4))  bus4 ();

  wb_regfile #(.RETIRE_W(32)) u_dut  (.cpu_clk(cpu_clk), .cpu_rst_n(cpu_rst_n), .bus(bus));
  wb_regfile #(.RETIRE_W(4))  u_dut4 (.cpu_clk(cpu_clk), .cpu_rst_n(cpu_rst_n), .bus(bus4));

  assign bus4.wb_valid = bus.wb_valid;
  assign bus4.wb_we    = bus.wb_we;
  assign bus4.wb_waddr = bus.wb_waddr;
  assign bus4.wb_wdata = bus.wb_wdata;
  assign bus4.wb_pc    = bus.wb_pc;
  assign bus4.rs1_addr = bus.rs1_addr;
  assign bus4.rs2_addr = bus.rs2_addr;

  typedef struct {
    logic [31:0] rs1, rs2, cnt;
    logic [3:0]  cnt4;
    logic        have, ena;
    logic [31:0] pc, val;
    logic [4:0]  rg;
  } exp_t;

  exp_t        q[$];
  int          n_chk = 0;
  int          n_pass = 0;

  // reference model: architectural state as plain arrays/integers
  logic [31:0] m_regs [32];
  int unsigned m_cnt;
  logic        t_have, t_ena;
  logic [31:0] t_pc, t_val;
  logic [4:0]  t_reg;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_cnt = 0;
    t_have = 0; t_ena = 0; t_pc = '0; t_val = '0; t_reg = '0;
  endfunction

  function automatic logic m_commit();
    return cpu_rst_n && bus.wb_valid && bus.wb_we && bus.wb_waddr != 5'd0;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (!cpu_rst_n || a == 5'd0) return '0;
    if (m_commit() && bus.wb_waddr == a) return bus.wb_wdata;
    return m_regs[a];
  endfunction

  function automatic void edge_update();
    if (!cpu_rst_n) begin
      model_reset();
    end else begin
      t_have = bus.wb_valid; t_pc = bus.wb_pc; t_ena = m_commit();
      t_reg = bus.wb_waddr;  t_val = bus.wb_wdata;
      if (m_commit()) m_regs[bus.wb_waddr] = bus.wb_wdata;
      if (bus.wb_valid) m_cnt++;
    end
  endfunction

  task automatic step(input logic rst, input logic v, input logic we, input logic [4:0] wa,
                      input logic [31:0] wd, input logic [31:0] pc,
                      input logic [4:0] a1, input logic [4:0] a2);
    exp_t e;
    @(posedge cpu_clk);
    edge_update();
    #1;
    cpu_rst_n = rst; bus.wb_valid = v; bus.wb_we = we; bus.wb_waddr = wa;
    bus.wb_wdata = wd; bus.wb_pc = pc; bus.rs1_addr = a1; bus.rs2_addr = a2;
    if (!rst) model_reset();
    e.rs1 = m_read(a1); e.rs2 = m_read(a2);
    e.cnt = m_cnt; e.cnt4 = 4'(m_cnt);
    e.have = t_have; e.ena = t_ena; e.pc = t_pc; e.val = t_val; e.rg = t_reg;
    q.push_back(e);
  endtask

  // monitor: pops one expectation per cycle, mid-cycle, away from the active edge
  initial begin
    exp_t e;
    forever begin
      @(negedge cpu_clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("rs1_data", bus.rs1_data, e.rs1);
        chk("rs2_data", bus.rs2_data, e.rs2);
        chk("retire_cnt", bus.retire_cnt, e.cnt);
        chk("rs1_data_w4", bus4.rs1_data, e.rs1);
        chk("retire_cnt_w4", 32'(bus4.retire_cnt), 32'(e.cnt4));
`ifdef RUN_TRACE_EN
        chk("trace_have", 32'(bus.debug_wb_have_inst), 32'(e.have));
        chk("trace_pc", bus.debug_wb_pc, e.pc);
        chk("trace_ena", 32'(bus.debug_wb_ena), 32'(e.ena));
        chk("trace_reg", 32'(bus.debug_wb_reg), 32'(e.rg));
        chk("trace_value", bus.debug_wb_value, e.val);
`endif
      end
    end
  end

  initial begin
    logic        r, v, we;
    logic [4:0]  wa, a1, a2;
    logic [31:0] wd, pc;
    cpu_rst_n = 1'b1;
    bus.wb_valid = 0; bus.wb_we = 0; bus.wb_waddr = '0; bus.wb_wdata = '0;
    bus.wb_pc = '0; bus.rs1_addr = '0; bus.rs2_addr = '0;
    model_reset();
    #1 cpu_rst_n = 1'b0;

    // reset held: every address reads 0 even with a live write request
    for (int i = 0; i < 32; i++) step(0, 1, 1, 5'(i), $urandom, '0, 5'(i), 5'(31 - i));
    step(1, 1, 1, 5'd5, 32'hDEADBEEF, '0, 5'd5, 5'd0);
    step(1, 0, 0, 5'd0, '0, '0, 5'd5, 5'd5);
    // same-cycle bypass on both ports, then the array holds it
    step(1, 1, 1, 5'd7, 32'h1234_5678, '0, 5'd7, 5'd7);
    step(1, 0, 0, 5'd0, '0, '0, 5'd7, 5'd5);
    // x0 write and squashed write
    step(1, 1, 1, 5'd0, 32'hFFFF_FFFF, '0, 5'd0, 5'd0);
    step(1, 0, 1, 5'd3, 32'hAA, '0, 5'd3, 5'd0);
    step(1, 0, 0, 5'd0, '0, '0, 5'd3, 5'd0);
    // 10 valid (mixed we) + 4 bubbles
    step(0, 0, 0, 5'd0, '0, '0, 5'd0, 5'd0);
    for (int i = 0; i < 14; i++)
      step(1, !(i == 2 || i == 5 || i == 8 || i == 11), 1'(i % 2), 5'(i + 1), $urandom, '0, 5'(i + 1), 5'(i));
    step(1, 0, 0, 5'd0, '0, '0, 5'd1, 5'd3);
    // 17 valid: 4-bit counter wraps to 1
    step(0, 0, 0, 5'd0, '0, '0, 5'd0, 5'd0);
    for (int i = 0; i < 17; i++) step(1, 1, 0, 5'(i), $urandom, '0, 5'(i), 5'd0);
    step(1, 0, 0, 5'd0, '0, '0, 5'd0, 5'd0);
    // mid-operation reset discards the pending commit
    step(1, 1, 1, 5'd9, 32'h55, '0, 5'd9, 5'd0);
    step(0, 1, 1, 5'd10, 32'h77, '0, 5'd9, 5'd10);
    step(1, 0, 0, 5'd0, '0, '0, 5'd9, 5'd10);
    // trace: real commit, then x0 write, then bubble
    step(1, 1, 1, 5'd2, 32'h42, 32'h8000_0010, 5'd2, 5'd0);
    step(1, 1, 1, 5'd0, 32'h5, 32'h8000_0014, 5'd2, 5'd0);
    step(1, 0, 0, 5'd0, '0, '0, 5'd0, 5'd2);

    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 59) != 0);
      v  = ($urandom_range(0, 3) != 0);
      we = ($urandom_range(0, 3) != 0);
      wa = 5'($urandom); wd = $urandom; pc = $urandom;
      a1 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom);
      a2 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom);
      step(r, v, we, wa, wd, pc, a1, a2);
    end

    for (int i = 0; i < 5 && q.size() != 0; i++) @(negedge cpu_clk);
    #1;
    chk("drain", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
